// File: rtl/key_debouncer.sv
// key_debouncer: synchronise, polarity-normalise and debounce raw push-buttons with press/release strobes
module key_debouncer #(
   parameter int KEY_W           = 4,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter bit KEY_ACTIVE_LOW  = 1
) (
   input  logic             clk50m_i,
   input  logic             rst_n_i,
   input  logic [KEY_W-1:0] key_raw_i,
   output logic [KEY_W-1:0] key_o,
   output logic [KEY_W-1:0] press_o,
   output logic [KEY_W-1:0] release_o,
   output logic             change_o
);
   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [KEY_W-1:0] IDLE = KEY_ACTIVE_LOW ? {KEY_W{1'b1}} : {KEY_W{1'b0}};
   typedef enum logic {ST_STABLE, ST_CONFIRM} state_t;
   logic [KEY_W-1:0] r_sync1;
   logic [KEY_W-1:0] r_sync2;
   logic [KEY_W-1:0] w_sample;
   logic [KEY_W-1:0] w_fire;
   logic             r_change;
   // two-flop synchroniser, reloaded with the released level so reset never looks like a press
   always_ff @(posedge clk50m_i) begin
      if (!rst_n_i) begin
         r_sync1 <= IDLE;
         r_sync2 <= IDLE;
      end else begin
         r_sync1 <= key_raw_i;
         r_sync2 <= r_sync1;
      end
   end
   assign w_sample = KEY_ACTIVE_LOW ? ~r_sync2 : r_sync2;
   for (genvar k = 0; k < KEY_W; k++) begin : g_key
      state_t        r_state;
      logic [CW-1:0] r_cnt;
      logic          r_key;
      logic          r_press;
      logic          r_release;
      assign w_fire[k] = (r_state == ST_CONFIRM) && (w_sample[k] != r_key) && (r_cnt == LAST);
      // per-key confirm FSM: a new level must disagree for DEBOUNCE_CYCLES consecutive cycles
      always_ff @(posedge clk50m_i) begin
         if (!rst_n_i) begin
            r_state   <= ST_STABLE;
            r_cnt     <= '0;
            r_key     <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
         end else begin
            r_press   <= w_fire[k] & w_sample[k];
            r_release <= w_fire[k] & ~w_sample[k];
            if (w_sample[k] == r_key) begin
               r_state <= ST_STABLE;
               r_cnt   <= '0;
            end else if (r_state == ST_STABLE) begin
               r_state <= ST_CONFIRM;
               r_cnt   <= CW'(1);
            end else if (w_fire[k]) begin
               r_key   <= w_sample[k];
               r_state <= ST_STABLE;
               r_cnt   <= '0;
            end else begin
               r_cnt   <= r_cnt + CW'(1);
            end
         end
      end
      assign key_o[k]     = r_key;
      assign press_o[k]   = r_press;
      assign release_o[k] = r_release;
   end
   // single registered change pulse aligned with the strobes, even when several keys fire together
   always_ff @(posedge clk50m_i) begin
      if (!rst_n_i) r_change <= 1'b0;
      else          r_change <= |w_fire;
   end
   assign change_o = r_change;
endmodule

// File: tb/tb_key_debouncer.sv
// tb_key_debouncer: scoreboard bench for key_debouncer with directed key patterns
module tb_key_debouncer;
   localparam int D = 4;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] raw = 4'hF;
   logic [3:0] key, press, rel;
   logic       change;
   int         cyc = 0;
   int         total = 0;
   int         bad = 0;
   typedef struct {
      int         cyc;
      logic [3:0] key;
      logic [3:0] press;
      logic [3:0] rel;
   } exp_t;
   exp_t q[$];

   key_debouncer #(.KEY_W(4), .DEBOUNCE_CYCLES(D), .KEY_ACTIVE_LOW(1)) dut (
      .clk50m_i (clk),
      .rst_n_i  (rst_n),
      .key_raw_i(raw),
      .key_o    (key),
      .press_o  (press),
      .release_o(rel),
      .change_o (change)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // monitor: every strobe/change cycle must match the next expected event
   always @(negedge clk) begin
      if ((change | (|press) | (|rel)) === 1'b1) begin
         if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_strobe: key=%h press=%h rel=%h change=%b at cycle %0d", key, press, rel, change, cyc);
         end else begin
            exp_t e;
            e = q.pop_front();
            check("event_cycle", cyc, e.cyc);
            check("event_key", int'(key), int'(e.key));
            check("event_press", int'(press), int'(e.press));
            check("event_release", int'(rel), int'(e.rel));
            check("event_change", int'(change), 1);
         end
      end
   end

   // drive a new raw level; it is first captured at the next edge, outputs follow D+1 edges later
   task automatic drive(input logic [3:0] v, input logic [3:0] k, input logic [3:0] p, input logic [3:0] r, input bit expect_evt);
      exp_t e;
      @(negedge clk);
      raw = v;
      if (expect_evt) begin
         e.cyc = cyc + 1 + D + 1;
         e.key = k;
         e.press = p;
         e.rel = r;
         q.push_back(e);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      // 1: reset with all keys released, then idle
      idle(3);
      check("rst_key", int'(key), 0);
      check("rst_press", int'(press), 0);
      check("rst_release", int'(rel), 0);
      check("rst_change", int'(change), 0);
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("idle_key", int'(key), 0);
      end
      // 2: clean press of key0
      drive(4'hE, 4'h1, 4'h1, 4'h0, 1);
      idle(10);
      check("press_level", int'(key), 1);
      // 4: release of key0
      drive(4'hF, 4'h0, 4'h0, 4'h1, 1);
      idle(10);
      check("release_level", int'(key), 0);
      // 3: bounce key1 three times, never long enough to be accepted
      for (int i = 0; i < 3; i++) begin
         drive(4'hD, 4'h0, 4'h0, 4'h0, 0);
         idle(2);
         drive(4'hF, 4'h0, 4'h0, 4'h0, 0);
      end
      check("bounce_level", int'(key), 0);
      drive(4'hD, 4'h2, 4'h2, 4'h0, 1);
      idle(10);
      check("bounce_hold_level", int'(key), 2);
      drive(4'hF, 4'h0, 4'h0, 4'h2, 1);
      idle(10);
      // 5: keys 2 and 3 together, then released together
      drive(4'h3, 4'hC, 4'hC, 4'h0, 1);
      idle(10);
      check("simul_level", int'(key), 12);
      drive(4'hF, 4'h0, 4'h0, 4'hC, 1);
      idle(10);
      // 6: reset two cycles into a key0 press; the press restarts after reset
      @(negedge clk);
      raw = 4'hE;
      idle(2);
      rst_n = 1'b0;
      @(negedge clk);
      check("midrst_key", int'(key), 0);
      rst_n = 1'b1;
      begin
         exp_t e;
         e.cyc = cyc + 1 + D + 1;
         e.key = 4'h1;
         e.press = 4'h1;
         e.rel = 4'h0;
         q.push_back(e);
      end
      idle(3);
      check("midrst_pending_key", int'(key), 0);
      idle(9);
      check("midrst_final_key", int'(key), 1);
      drive(4'hF, 4'h0, 4'h0, 4'h1, 1);
      idle(10);
      check("pending_events", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
